sram_stream_reader: RTL and testbench
=====================================

# sram_stream_reader

Streaming read engine for the 16384 x 16-bit dual-port SRAM banks. It sits directly upstream of the NPU datapath and drives one SRAM port as an Avalon-style master. On a start command it reads `length` consecutive (or strided) words beginning at `base_addr`. It delivers them on a valid/ready stream, and an internal credit-limited FIFO absorbs the SRAM's fixed 1-cycle read latency and any downstream back-pressure.

## Interface
Parameters:
- `ADDR_W`, 14: SRAM word-address width.
- `DATA_W`, 16: SRAM and stream data width.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, ≥ 2.

Ports:
- `clk`, in, 1: sole clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: single-cycle command strobe; sampled only in IDLE.
- `base_addr`, in, ADDR_W: first word address; captured on accepted `start`.
- `length`, in, ADDR_W+1: word count, 0..16384; captured on accepted `start`.
- `stride`, in, ADDR_W: address increment; present only with `SRAM_RD_STRIDE_EN`.
- `busy`, out, 1: high from the accepted `start` until `done`.
- `done`, out, 1: one-cycle completion pulse.
- `mem_address`, out, ADDR_W: SRAM port address.
- `mem_chipselect`, out, 1: read-issue strobe.
- `mem_write`, out, 1: constant 0.
- `mem_byteenable`, out, 2: constant 2'b11.
- `mem_readdata`, in, DATA_W: SRAM read data, valid the cycle after issue.
- `out_data`, out, DATA_W: stream data (FIFO head).
- `out_valid`, out, 1: stream valid.
- `out_ready`, in, 1: stream ready.
- `out_last`, out, 1: marks the final word of a command.

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE → RUN on `start` with `length` ≠ 0.
  - IDLE stays IDLE on `start` with `length` = 0, and `done` pulses on the next cycle with no reads issued.
  - RUN → DRAIN once the issued count reaches `length`.
  - DRAIN → IDLE on the handshake of the word with `out_last`; `done` pulses on that same transition.
- `start` is ignored while `busy` is high.
- Issue rule: in RUN, assert `mem_chipselect` when `fifo_count + inflight < FIFO_DEPTH`.
  - `inflight` is 1 when a read was issued on the previous cycle.
  - The FIFO can therefore never overflow, and no read is ever dropped or reissued.
- Address: `addr_next = (addr + step) mod 2^ADDR_W`, where `step` is 1, or `stride` when the macro is enabled. Wrap past 16383 to 0 is legal and silent.
- Capture: the cycle after an issue, `mem_readdata` is written into the FIFO unconditionally.
- `out_last` is attached to the word whose issue index equals `length`−1.
- Stream rules:
  - Transfer occurs when `out_valid` & `out_ready`.
  - `out_valid`, `out_data` and `out_last` stay stable until the transfer completes.
  - Simultaneous FIFO push and pop in the same cycle are both honoured, and the count is unchanged.
- Reset (any time, including mid-command): return to IDLE, flush the FIFO, drop any in-flight read, clear all counters.
- Reset values: `busy`=0, `done`=0, `mem_chipselect`=0, `mem_address`=0, `out_valid`=0, `out_last`=0, `out_data`=0. `mem_write`=0 and `mem_byteenable`=2'b11 at all times.

## Timing
- Cycle 0: `start` accepted in IDLE.
- Cycle 1: `busy`=1, `mem_chipselect`=1, `mem_address`=`base_addr`.
- Cycle 2: SRAM data present and pushed into the FIFO at the end of the cycle.
- Cycle 3: `out_valid`=1, so latency from `start` to the first word is 3 cycles.
- With `out_ready` held high, throughput is 1 word per cycle. An N-word command gives `done` at cycle N+3, and `busy` falls at cycle N+4.
- After `done`, a new `start` is accepted in the next cycle (back-to-back commands, one idle cycle).
- `out_ready` low stalls issue within 1 cycle of the FIFO credit being exhausted. No more than FIFO_DEPTH words are ever buffered or in flight.

## Configuration
- `SRAM_RD_STRIDE_EN`, when defined:
  - The `stride` port exists and is captured with `start`.
  - The address advances by `stride`, modulo 2^14.
  - `stride`=0 is legal and re-reads the same word `length` times.
- When undefined: there is no `stride` port, and the address always advances by 1.

## Test plan
- Basic: preload words 0x1000+i at addresses 0x0100..0x010F, send `start` with base=0x0100, length=16, and hold `out_ready`=1. Required: 16 beats 0x1000..0x100F on consecutive cycles starting at cycle 3, `out_last` on beat 15, `done` at cycle 19.
- Back-pressure: same command, with `out_ready` toggling 1,0,0,1,… at random. Required: identical ordered data, never more than 4 words outstanding (FIFO plus in-flight), data stable while stalled.
- Wrap: base=0x3FFE, length=4. Required: reads from 0x3FFE, 0x3FFF, 0x0000, 0x0001, in order.
- Edge commands:
  - length=0: `done` one cycle after `start`, no `mem_chipselect`.
  - `start` pulsed while `busy`: ignored, stream unchanged.
- Reset mid-run: assert `reset` after 5 of 16 beats. Required: all outputs at their reset values the next cycle, and a subsequent command (base=0, length=2) returns the correct 2 words.
- Stride (macro defined): base=0x0010, length=4, stride=3. Required: reads from 0x10, 0x13, 0x16, 0x19.

Source files
------------

// File: rtl/sram_stream_reader.sv
// sram_stream_reader
//   Streaming read engine for a 16384 x 16 SRAM port (Avalon-style master).
//   A start command captures base_addr/length and the engine then issues
//   reads while output FIFO credit allows. Each word is captured one cycle
//   after issue and delivered on a valid/ready stream, with out_last on the
//   final word of the command.
//
//   Optional feature: define SRAM_RD_STRIDE_EN to add the stride port. The
//   address then advances by the captured stride instead of by 1.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   start             : command strobe, accepted only when idle and not busy
//   base_addr, length : command parameters, captured on an accepted start
//   stride            : address step (only with SRAM_RD_STRIDE_EN)
//   busy, done        : command in progress / one-cycle completion pulse
//   mem_*             : SRAM master port (read-only, 1-cycle read latency)
//   out_data, out_valid, out_ready, out_last : output stream
//
// Handshake: a word transfers on a cycle where out_valid && out_ready are
// both high. Once out_valid is raised, out_data/out_last hold steady until
// that transfer; out_ready may toggle freely and never affects out_valid.
module sram_stream_reader #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
`ifdef SRAM_RD_STRIDE_EN
  input  logic [ADDR_W-1:0] stride,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [1:0]        mem_byteenable,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // state is kept as a named signal so checkers can bind to it directly
  state_t state, state_next;

  logic              done_q, done_next;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   length_q;
  logic [ADDR_W:0]   issue_cnt;
  logic              inflight_q;
  logic              inflight_last_q;
  logic [ADDR_W-1:0] step;

  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic              fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occ;

  logic accept, issue, last_issue, push, pop;

`ifdef SRAM_RD_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;
  assign step = stride_q;
`else
  assign step = ADDR_W'(1);
`endif

  // Credit: words already in the FIFO plus the read whose data lands this
  // cycle. Issuing only below FIFO_DEPTH means a captured word always fits.
  assign occ        = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
  assign accept     = (state == S_IDLE) && !done_q && start;
  assign issue      = (state == S_RUN) && (occ < DEPTH_V);
  assign last_issue = (issue_cnt == length_q - 1'b1);
  assign push       = inflight_q;
  assign pop        = out_valid && out_ready;

  assign busy           = (state != S_IDLE) || done_q;
  assign done           = done_q;
  assign mem_address    = addr_q;
  assign mem_chipselect = issue;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 2'b11;

  // Storage is not reset; outputs are gated so they read 0 while empty.
  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_last  = out_valid && fifo_last[rd_ptr];

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (length != '0) state_next = S_RUN;
          else              done_next  = 1'b1;
        end
      end
      S_RUN: begin
        if (issue && last_issue) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && out_last) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      done_q          <= 1'b0;
      addr_q          <= '0;
      length_q        <= '0;
      issue_cnt       <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_count      <= '0;
`ifdef SRAM_RD_STRIDE_EN
      stride_q        <= '0;
`endif
    end else begin
      state  <= state_next;
      done_q <= done_next;
      if (accept) begin
        addr_q    <= base_addr;
        length_q  <= length;
        issue_cnt <= '0;
`ifdef SRAM_RD_STRIDE_EN
        stride_q  <= stride;
`endif
      end else if (issue) begin
        addr_q    <= addr_q + step;   // wraps modulo 2^ADDR_W
        issue_cnt <= issue_cnt + 1'b1;
      end
      inflight_q      <= issue;
      inflight_last_q <= issue && last_issue;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Read data is captured unconditionally the cycle after an issue.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_readdata;
      fifo_last[wr_ptr] <= inflight_last_q;
    end
  end

endmodule

// File: tb/tb_sram_stream_reader.sv
// tb_sram_stream_reader
//   Directed bench for sram_stream_reader with a behavioural 1-cycle-latency
//   SRAM, an expected-word queue and an expected-address queue. Runs the
//   default build; the stride case is included when SRAM_RD_STRIDE_EN is set.
module tb_sram_stream_reader;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   length = '0;
  logic [ADDR_W-1:0] stride_r = 14'd1;
  logic              busy, done;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect, mem_write;
  logic [1:0]        mem_byteenable;
  logic [DATA_W-1:0] mem_readdata = '0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid, out_last;
  logic              out_ready = 1'b1;

  sram_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .length         (length),
`ifdef SRAM_RD_STRIDE_EN
    .stride         (stride_r),
`endif
    .busy           (busy),
    .done           (done),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_readdata   (mem_readdata),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last)
  );

  // ---------------- SRAM model ----------------
  logic [DATA_W-1:0] sram [1 << ADDR_W];
  always @(posedge clk) begin
    if (mem_chipselect) mem_readdata <= sram[mem_address];
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DATA_W:0]   exp_q[$];   // {last, data}
  logic [ADDR_W-1:0] addr_q[$];
  logic mon_en = 1'b0;
  int iss_cnt = 0;
  int pop_cnt = 0;
  logic stall_prev = 1'b0;
  logic [DATA_W-1:0] stall_data;
  logic stall_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [DATA_W:0]   e;
    logic [ADDR_W-1:0] ea;
    if (mon_en) begin
      if (mem_chipselect) begin
        iss_cnt++;
        check("issue_expected", 32'(addr_q.size() != 0), 1);
        if (addr_q.size() != 0) begin
          ea = addr_q.pop_front();
          check("mem_address", 32'(mem_address), 32'(ea));
        end
        check("outstanding_le_4", 32'((iss_cnt - pop_cnt) <= 4), 1);
        check("mem_write", 32'(mem_write), 0);
      end
      if (stall_prev) begin
        check("stall_valid", 32'(out_valid), 1);
        check("stall_data", 32'(out_data), 32'(stall_data));
        check("stall_last", 32'(out_last), 32'(stall_last));
      end
      if (out_valid && out_ready) begin
        pop_cnt++;
        check("beat_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e[DATA_W-1:0]));
          check("out_last", 32'(out_last), 32'(e[DATA_W]));
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      stall_last = out_last;
    end else begin
      iss_cnt    = 0;
      pop_cnt    = 0;
      stall_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_cmd(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n,
                          input logic [ADDR_W-1:0] stp);
    logic [ADDR_W-1:0] a;
    a = b;
    for (int i = 0; i < int'(n); i++) begin
      exp_q.push_back({(i == int'(n) - 1), sram[a]});
      addr_q.push_back(a);
      a = a + stp;
    end
  endtask

  // Returns at posedge+1 of cycle 1 (the start strobe occupied cycle 0).
  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n,
                          input logic [ADDR_W-1:0] stp);
    @(posedge clk); #1;
    base_addr = b;
    length    = n;
    stride_r  = stp;
    start     = 1'b1;
    push_cmd(b, n, stp);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    check("done_seen", 32'(done), 1);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_data_q_empty"}, 32'(exp_q.size()), 0);
    check({tag, "_addr_q_empty"}, 32'(addr_q.size()), 0);
  endtask

  task automatic check_reset_vals();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_chipselect", 32'(mem_chipselect), 0);
    check("rst_address", 32'(mem_address), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_last", 32'(out_last), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_write", 32'(mem_write), 0);
    check("rst_byteenable", 32'(mem_byteenable), 3);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int p0;
    for (int i = 0; i < (1 << ADDR_W); i++) sram[i] = 16'(i * 37 + 5);
    for (int i = 0; i < 16; i++) sram[14'h0100 + i] = 16'(16'h1000 + i);

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // basic: 16 words, ready high, exact cycle timing
    do_start(14'h0100, 15'd16, 14'd1);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      check($sformatf("basic_busy_c%0d", k), 32'(busy), 32'(k <= 19));
      check($sformatf("basic_done_c%0d", k), 32'(done), 32'(k == 19));
      check($sformatf("basic_valid_c%0d", k), 32'(out_valid), 32'(k >= 3 && k <= 18));
      check($sformatf("basic_cs_c%0d", k), 32'(mem_chipselect), 32'(k <= 16));
    end
    check_drained("basic");

    // back-pressure: random ready, same command
    do_start(14'h0100, 15'd16, 14'd1);
    n = 0;
    do begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
      if (!done) begin
        @(posedge clk); #1;
      end
    end while (!done && n < 300);
    check("bp_done_seen", 32'(done), 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    check_drained("bp");

    // address wrap
    do_start(14'h3FFE, 15'd4, 14'd1);
    wait_done(40);
    check_drained("wrap");

    // length 0: done next cycle, no reads
    do_start(14'h0123, 15'd0, 14'd1);
    @(negedge clk);
    check("len0_done", 32'(done), 1);
    check("len0_cs", 32'(mem_chipselect), 0);
    @(negedge clk);
    check("len0_done_clear", 32'(done), 0);
    check("len0_busy_clear", 32'(busy), 0);

    // start while busy is ignored
    do_start(14'h0200, 15'd6, 14'd1);
    @(posedge clk); #1;
    base_addr = 14'h0300;
    length    = 15'd3;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40);
    repeat (8) @(negedge clk);
    check("ignored_idle_busy", 32'(busy), 0);
    check_drained("ignored");

    // reset mid-run after 5 beats
    p0 = pop_cnt;
    do_start(14'h0100, 15'd16, 14'd1);
    n = 0;
    while ((pop_cnt - p0) < 5 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("midrun_five_beats", 32'((pop_cnt - p0) >= 5), 1);
    @(posedge clk); #1;
    reset  = 1'b1;
    mon_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    mon_en = 1'b1;
    do_start(14'h0000, 15'd2, 14'd1);
    wait_done(40);
    check_drained("post_reset");

`ifdef SRAM_RD_STRIDE_EN
    // strided read
    do_start(14'h0010, 15'd4, 14'd3);
    wait_done(40);
    check_drained("stride");
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
